// File: rtl/rtc_field_edit_ctrl.sv
// Sequencer for the RTC time/date field register bank: periodic refresh reads,
// the user edit session (field select, up/down routing) and the write-back.
module rtc_field_edit_ctrl #(
  parameter int unsigned N_FIELDS       = 6,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BTN_EDIT,
  input  logic                BTN_NEXT,
  input  logic                BTN_UP,
  input  logic                BTN_DOWN,
  input  logic                RD_ACK,
  input  logic                WR_ACK,
  output logic                RD_REQ,
  output logic                WR_REQ,
  output logic [N_FIELDS-1:0] MOD_EN,
  output logic [N_FIELDS-1:0] UP_OUT,
  output logic [N_FIELDS-1:0] DOWN_OUT,
  output logic                UPDATE,
  output logic [2:0]          FIELD_SEL,
  output logic                EDITING
);

  localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      SelLast = 3'(N_FIELDS - 1);

  typedef enum logic [1:0] {StIdle, StReadWait, StEdit, StWriteWait} state_e;

  state_e              state_q, state_d;
  logic [RefW-1:0]     refresh_q, refresh_d;
  logic [ToW-1:0]      timeout_q, timeout_d;
  logic                pend_q, pend_d;
  logic [2:0]          field_sel_q, field_sel_d;
  logic [N_FIELDS-1:0] mod_en_q, mod_en_d;
  logic [N_FIELDS-1:0] up_q, up_d;
  logic [N_FIELDS-1:0] down_q, down_d;
  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic                update_q, update_d;
  logic                editing_q, editing_d;
  logic                any_btn;

  function automatic logic [N_FIELDS-1:0] onehot(input logic [2:0] sel);
    onehot = N_FIELDS'(1) << sel;
  endfunction

  assign any_btn = BTN_EDIT | BTN_NEXT | BTN_UP | BTN_DOWN;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    refresh_d   = refresh_q;
    timeout_d   = timeout_q;
    pend_d      = pend_q;
    field_sel_d = field_sel_q;
    mod_en_d    = mod_en_q;
    up_d        = '0;
    down_d      = '0;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    update_d    = 1'b0;
    editing_d   = editing_q;

    unique case (state_q)
      StIdle: begin
        // Entering edit beats a refresh expiring in the same cycle.
        if (BTN_EDIT || pend_q) begin
          state_d     = StEdit;
          pend_d      = 1'b0;
          field_sel_d = 3'd0;
          mod_en_d    = onehot(3'd0);
          editing_d   = 1'b1;
          timeout_d   = '0;
          refresh_d   = '0;
        end else if (refresh_q == RefLast) begin
          refresh_d = '0;
          rd_req_d  = 1'b1;
          state_d   = StReadWait;
        end else begin
          refresh_d = refresh_q + 1'b1;
        end
      end

      StReadWait: begin
        // The bus read is never aborted; an edit request waits for IDLE.
        if (BTN_EDIT) pend_d = 1'b1;
        if (RD_ACK) begin
          rd_req_d  = 1'b0;
          update_d  = 1'b1;
          refresh_d = '0;
          state_d   = StIdle;
        end
      end

      StEdit: begin
        // Pulses go to the field selected before any NEXT in this cycle.
        if (BTN_UP) begin
          up_d = onehot(field_sel_q);
        end else if (BTN_DOWN) begin
          down_d = onehot(field_sel_q);
        end

        if (BTN_EDIT) begin
          mod_en_d = '0;
          wr_req_d = 1'b1;
          state_d  = StWriteWait;
        end else if (BTN_NEXT) begin
          field_sel_d = (field_sel_q == SelLast) ? 3'd0 : field_sel_q + 3'd1;
          mod_en_d    = onehot(field_sel_d);
        end else if (!any_btn && (timeout_q == ToLast)) begin
          // Abandon the session and reload the untouched RTC values.
          mod_en_d  = '0;
          editing_d = 1'b0;
          rd_req_d  = 1'b1;
          state_d   = StReadWait;
        end

        timeout_d = (any_btn || (timeout_q == ToLast)) ? '0 : timeout_q + 1'b1;
      end

      StWriteWait: begin
        if (WR_ACK) begin
          wr_req_d  = 1'b0;
          rd_req_d  = 1'b1;
          editing_d = 1'b0;
          state_d   = StReadWait;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      refresh_q   <= '0;
      timeout_q   <= '0;
      pend_q      <= 1'b0;
      field_sel_q <= 3'd0;
      mod_en_q    <= '0;
      up_q        <= '0;
      down_q      <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      update_q    <= 1'b0;
      editing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      refresh_q   <= refresh_d;
      timeout_q   <= timeout_d;
      pend_q      <= pend_d;
      field_sel_q <= field_sel_d;
      mod_en_q    <= mod_en_d;
      up_q        <= up_d;
      down_q      <= down_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      update_q    <= update_d;
      editing_q   <= editing_d;
    end
  end

  assign RD_REQ    = rd_req_q;
  assign WR_REQ    = wr_req_q;
  assign MOD_EN    = mod_en_q;
  assign UP_OUT    = up_q;
  assign DOWN_OUT  = down_q;
  assign UPDATE    = update_q;
  assign FIELD_SEL = field_sel_q;
  assign EDITING   = editing_q;

endmodule

// File: tb/tb_rtc_field_edit_ctrl.sv
// Cycle-by-cycle vector bench for rtc_field_edit_ctrl with short timer parameters.
module tb_rtc_field_edit_ctrl;

  localparam int unsigned NF = 6;
  localparam int unsigned RC = 8;
  localparam int unsigned TC = 20;

  typedef struct packed {
    logic ed, nx, up, dn, rack, wack;
  } in_t;

  typedef struct packed {
    logic          rd, wr;
    logic [NF-1:0] mod, upo, dno;
    logic          upd;
    logic [2:0]    sel;
    logic          edt;
  } out_t;

  typedef struct {
    string name;
    in_t   vin;
    out_t  exp;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN, RD_ACK, WR_ACK;
  logic          RD_REQ, WR_REQ, UPDATE, EDITING;
  logic [NF-1:0] MOD_EN, UP_OUT, DOWN_OUT;
  logic [2:0]    FIELD_SEL;

  vec_t  vecs[$];
  out_t  expq[$];
  string nameq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 CLK = ~CLK;

  rtc_field_edit_ctrl #(
    .N_FIELDS      (NF),
    .REFRESH_CYCLES(RC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_EDIT (BTN_EDIT),
    .BTN_NEXT (BTN_NEXT),
    .BTN_UP   (BTN_UP),
    .BTN_DOWN (BTN_DOWN),
    .RD_ACK   (RD_ACK),
    .WR_ACK   (WR_ACK),
    .RD_REQ   (RD_REQ),
    .WR_REQ   (WR_REQ),
    .MOD_EN   (MOD_EN),
    .UP_OUT   (UP_OUT),
    .DOWN_OUT (DOWN_OUT),
    .UPDATE   (UPDATE),
    .FIELD_SEL(FIELD_SEL),
    .EDITING  (EDITING)
  );

  function automatic in_t ib(input logic ed, nx, up, dn, rack, wack);
    in_t r;
    r = '{ed: ed, nx: nx, up: up, dn: dn, rack: rack, wack: wack};
    return r;
  endfunction

  function automatic out_t ob(input logic rd, wr, input logic [NF-1:0] mod, upo, dno,
                              input logic upd, input logic [2:0] sel, input logic edt);
    out_t r;
    r = '{rd: rd, wr: wr, mod: mod, upo: upo, dno: dno, upd: upd, sel: sel, edt: edt};
    return r;
  endfunction

  function automatic out_t actual();
    out_t r;
    r = '{rd: RD_REQ, wr: WR_REQ, mod: MOD_EN, upo: UP_OUT, dno: DOWN_OUT, upd: UPDATE,
          sel: FIELD_SEL, edt: EDITING};
    return r;
  endfunction

  task automatic add(input string nm, input in_t vin, input out_t vexp);
    vec_t v;
    v.name = nm;
    v.vin  = vin;
    v.exp  = vexp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input out_t got, input out_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got rd=%b wr=%b mod=%b up=%b dn=%b upd=%b sel=%0d edt=%b, expected rd=%b wr=%b mod=%b up=%b dn=%b upd=%b sel=%0d edt=%b",
               nm, got.rd, got.wr, got.mod, got.upo, got.dno, got.upd, got.sel, got.edt,
               want.rd, want.wr, want.mod, want.upo, want.dno, want.upd, want.sel, want.edt);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    out_t  e;
    string nm;
    {BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN, RD_ACK, WR_ACK} = v.vin;
    expq.push_back(v.exp);
    nameq.push_back(v.name);
    @(posedge CLK);
    #1;
    e  = expq.pop_front();
    nm = nameq.pop_front();
    chk(nm, actual(), e);
  endtask

  initial begin
    in_t  none;
    out_t o0;
    vec_t v;
    logic [2:0] s;

    none = '0;
    o0   = '0;

    // Refresh cadence, spurious acks in IDLE ignored.
    for (int k = 1; k <= 7; k++)
      add("idle_wait", (k == 3) ? ib(0, 0, 0, 0, 1, 0) : (k == 4) ? ib(0, 0, 0, 0, 0, 1) : none,
          o0);
    add("refresh_req", none, ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("rd_hold", none, ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("rd_hold", none, ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("update_pulse", ib(0, 0, 0, 0, 1, 0), ob(0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 7; k++) add("refresh_gap", none, o0);
    add("refresh_req2", none, ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("update_pulse2", ib(0, 0, 0, 0, 1, 0), ob(0, 0, 0, 0, 0, 1, 0, 0));

    // Edit session: select field 2, UP, UP, DOWN.
    add("edit_enter", ib(1, 0, 0, 0, 0, 0), ob(0, 0, 6'b000001, 0, 0, 0, 0, 1));
    add("next_1", ib(0, 1, 0, 0, 0, 0), ob(0, 0, 6'b000010, 0, 0, 0, 1, 1));
    add("next_2", ib(0, 1, 0, 0, 0, 0), ob(0, 0, 6'b000100, 0, 0, 0, 2, 1));
    add("up_a", ib(0, 0, 1, 0, 0, 0), ob(0, 0, 6'b000100, 6'b000100, 0, 0, 2, 1));
    add("up_a_end", none, ob(0, 0, 6'b000100, 0, 0, 0, 2, 1));
    add("up_b", ib(0, 0, 1, 0, 0, 0), ob(0, 0, 6'b000100, 6'b000100, 0, 0, 2, 1));
    add("down_a", ib(0, 0, 0, 1, 0, 0), ob(0, 0, 6'b000100, 0, 6'b000100, 0, 2, 1));
    add("down_a_end", none, ob(0, 0, 6'b000100, 0, 0, 0, 2, 1));
    // Walk 2 -> 3,4,5,0 then a full lap of six back to 0.
    for (int k = 0; k < 4; k++) begin
      s = 3'((3 + k) % NF);
      add("next_wrap", ib(0, 1, 0, 0, 0, 0), ob(0, 0, 6'(1) << s, 0, 0, 0, s, 1));
    end
    for (int k = 0; k < 6; k++) begin
      s = 3'((k + 1) % NF);
      add("next_lap", ib(0, 1, 0, 0, 0, 0), ob(0, 0, 6'(1) << s, 0, 0, 0, s, 1));
    end
    add("up_down_same", ib(0, 0, 1, 1, 0, 0), ob(0, 0, 6'b000001, 6'b000001, 0, 0, 0, 1));
    add("up_next_same", ib(0, 1, 1, 0, 0, 0), ob(0, 0, 6'b000010, 6'b000001, 0, 0, 1, 1));
    add("edit_exit_up", ib(1, 0, 1, 0, 0, 0), ob(0, 1, 0, 6'b000010, 0, 0, 1, 1));

    // Write-back: buttons and a stray read ack are ignored, WR_ACK on the fifth cycle.
    add("ww_hold", none, ob(0, 1, 0, 0, 0, 0, 1, 1));
    add("ww_btn_ignored", ib(1, 1, 1, 0, 0, 0), ob(0, 1, 0, 0, 0, 0, 1, 1));
    add("ww_spur_rack", ib(0, 0, 0, 0, 1, 0), ob(0, 1, 0, 0, 0, 0, 1, 1));
    add("ww_hold", none, ob(0, 1, 0, 0, 0, 0, 1, 1));
    add("wr_ack_resync", ib(0, 0, 0, 0, 0, 1), ob(1, 0, 0, 0, 0, 0, 1, 0));
    add("resync_hold", none, ob(1, 0, 0, 0, 0, 0, 1, 0));
    add("resync_hold", ib(0, 0, 0, 0, 0, 1), ob(1, 0, 0, 0, 0, 0, 1, 0));
    add("resync_update", ib(0, 0, 0, 0, 1, 0), ob(0, 0, 0, 0, 0, 1, 1, 0));

    // Timeout: no buttons for TC cycles abandons the session without a write.
    add("to_enter", ib(1, 0, 0, 0, 0, 0), ob(0, 0, 6'b000001, 0, 0, 0, 0, 1));
    for (int k = 1; k < TC; k++) add("to_wait", none, ob(0, 0, 6'b000001, 0, 0, 0, 0, 1));
    add("to_expire", none, ob(1, 0, 0, 0, 0, 0, 0, 0));

    // BTN_EDIT during READ_WAIT is held until the read completes.
    add("rw_edit_pending", ib(1, 0, 0, 0, 0, 0), ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("rw_up_ignored", ib(0, 0, 1, 0, 0, 0), ob(1, 0, 0, 0, 0, 0, 0, 0));
    add("rw_update", ib(0, 0, 0, 0, 1, 0), ob(0, 0, 0, 0, 0, 1, 0, 0));
    add("pending_enter", none, ob(0, 0, 6'b000001, 0, 0, 0, 0, 1));
    add("pending_exit", ib(1, 0, 0, 0, 0, 0), ob(0, 1, 0, 0, 0, 0, 0, 1));
    add("ww2_hold", none, ob(0, 1, 0, 0, 0, 0, 0, 1));

    RST = 1'b1;
    {BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN, RD_ACK, WR_ACK} = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", actual(), o0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset in the middle of WRITE_WAIT, away from any clock edge.
    #3;
    RST = 1'b1;
    #1;
    chk("async_rst_mid_ww", actual(), o0);
    @(negedge CLK);
    RST = 1'b0;
    v.vin = none;
    v.exp = o0;
    v.name = "post_rst_idle";
    for (int k = 0; k < 3; k++) apply(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_field_edit_ctrl.md
Name: rtc_field_edit_ctrl

Overview:
Sequencer for the bank of BCD time/date field registers (seconds, minutes, hours, day, month, year) in the RTC interface.
- Periodically requests an RTC read and broadcasts the update strobe so every field register loads fresh data.
- Runs the user edit session: selects one field, routes UP/DOWN pulses to it, then requests a write-back to the RTC.
- Sits between the debounced button logic, the field registers and the RTC bus controller.

Parameters:
N_FIELDS, 6, number of field registers; field index 0..N_FIELDS-1.
REFRESH_CYCLES, 1000000, CLK cycles between automatic read requests in IDLE.
TIMEOUT_CYCLES, 50000000, CLK cycles without any button pulse before an edit session is abandoned.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-high.
BTN_EDIT  in  1  one-cycle pulse (pre-debounced); enter/leave edit mode.
BTN_NEXT  in  1  one-cycle pulse; select next field.
BTN_UP  in  1  one-cycle pulse; increment selected field.
BTN_DOWN  in  1  one-cycle pulse; decrement selected field.
RD_ACK  in  1  bus controller: read done, field data valid this cycle.
WR_ACK  in  1  bus controller: write done.
RD_REQ  out  1  read request, level, held until RD_ACK.
WR_REQ  out  1  write request, level, held until WR_ACK.
MOD_EN  out  N_FIELDS  one-hot modify enable per field register.
UP_OUT  out  N_FIELDS  one-cycle increment pulse per field.
DOWN_OUT  out  N_FIELDS  one-cycle decrement pulse per field.
UPDATE  out  1  one-cycle load strobe broadcast to all field registers.
FIELD_SEL  out  3  index of selected field.
EDITING  out  1  high in EDIT and WRITE_WAIT.

Behaviour:
- Reset (async): state IDLE; all outputs 0; FIELD_SEL=0; refresh/timeout counters 0; pending-edit flag 0. Reset mid-transaction drops RD_REQ/WR_REQ immediately; no ack is awaited.
- All outputs registered.
- States: IDLE, READ_WAIT, EDIT, WRITE_WAIT.
- IDLE:
  - Refresh counter increments each cycle. At REFRESH_CYCLES-1: counter->0, RD_REQ=1 next cycle, go READ_WAIT.
  - BTN_EDIT (or pending flag set) -> EDIT with FIELD_SEL=0. This takes priority over a refresh expiring in the same cycle.
- READ_WAIT:
  - RD_REQ held high.
  - On RD_ACK: RD_REQ=0 and UPDATE=1 for exactly the next cycle; go IDLE; refresh counter->0.
  - BTN_EDIT here sets the pending flag (bus transaction never aborted); the flag is consumed in IDLE.
  - Other buttons ignored.
- EDIT:
  - MOD_EN = one-hot(FIELD_SEL); EDITING=1.
  - Button pulse sampled at edge N -> UP_OUT[FIELD_SEL] or DOWN_OUT[FIELD_SEL] high during cycle N+1 only.
  - BTN_UP and BTN_DOWN together: UP only.
  - BTN_NEXT: FIELD_SEL+1, wrapping N_FIELDS-1 -> 0; MOD_EN follows next cycle. BTN_NEXT with BTN_UP in the same cycle: the pulse goes to the old field and the selection then advances.
  - BTN_EDIT: MOD_EN->0, WR_REQ=1, go WRITE_WAIT. BTN_EDIT with UP in the same cycle: the UP pulse is still issued.
  - Timeout counter clears on any button pulse. At TIMEOUT_CYCLES-1: MOD_EN->0, no write, go READ_WAIT with RD_REQ=1 to restore RTC values.
- WRITE_WAIT:
  - MOD_EN=0; WR_REQ held; EDITING=1; buttons ignored.
  - On WR_ACK: WR_REQ=0, RD_REQ=1, go READ_WAIT (resync).
- Invariants:
  - UPDATE never high while any MOD_EN bit is high.
  - RD_REQ and WR_REQ never both high.
  - At most one bit of UP_OUT|DOWN_OUT high in any cycle.
- Spurious RD_ACK/WR_ACK in a state not waiting for it: ignored.

Test Plan:
- REFRESH_CYCLES=8, idle: RD_REQ rises 8 cycles after reset release; RD_ACK 3 cycles later -> UPDATE high exactly 1 cycle, next RD_REQ 8 cycles after that.
- BTN_EDIT in IDLE, then NEXT x2, UP, UP, DOWN: MOD_EN=6'b000100, UP_OUT[2] pulses twice, DOWN_OUT[2] once, each 1 cycle after its button.
- N_FIELDS=6, NEXT x6 from field 0 -> FIELD_SEL returns to 0; UP and DOWN in the same cycle -> only UP_OUT[0] pulses.
- BTN_EDIT to finish -> WR_REQ high, MOD_EN=0. WR_ACK after 5 cycles -> RD_REQ next cycle, then UPDATE after RD_ACK; EDITING low once in READ_WAIT.
- TIMEOUT_CYCLES=20: enter edit, no buttons for 20 cycles -> MOD_EN=0, RD_REQ=1, WR_REQ never asserted.
- BTN_EDIT during READ_WAIT -> EDIT entered right after RD_ACK/UPDATE. RST asserted mid-WRITE_WAIT -> WR_REQ=0 asynchronously, state IDLE, FIELD_SEL=0.
